// File: rtl/cipher_block_sequencer.sv
// cipher_block_sequencer: gathers Rx bytes into a block, runs the cipher core, serialises the result to Tx
module cipher_block_sequencer #(
  parameter int BLOCK_BYTES  = 8,
  parameter int CORE_TIMEOUT = 255,
  localparam int W = 8 * BLOCK_BYTES
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         key_ready_i,
  input  logic         is_encrypt_i,
  input  logic         rx_empty_i,
  input  logic [7:0]   rx_data_i,
  output logic         rx_deq_o,
  output logic         core_start_o,
  output logic         core_mode_o,
  output logic [W-1:0] core_block_in_o,
  input  logic         core_done_i,
  input  logic [W-1:0] core_block_out_i,
  input  logic         tx_full_i,
  output logic [7:0]   tx_data_o,
  output logic         tx_enq_o,
  input  logic         err_clr_i,
  output logic         busy_o,
  output logic         timeout_err_o,
  output logic [15:0]  block_count_o
);
  localparam int CW = $clog2(BLOCK_BYTES);
  localparam logic [CW-1:0] LAST = CW'(BLOCK_BYTES - 1);
  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, UNLOAD} state_t;
  state_t state_q, state_d;
  logic mode_q, mode_d, err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] blk_q, blk_d, out_q, out_d;
  logic [15:0] wcnt_q, wcnt_d, bc_q, bc_d;
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      blk_q   <= '0;
      out_q   <= '0;
      wcnt_q  <= '0;
      bc_q    <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      out_q   <= out_d;
      wcnt_q  <= wcnt_d;
      bc_q    <= bc_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    err_d    = err_clr_i ? 1'b0 : err_q;
    cnt_d    = cnt_q;
    blk_d    = blk_q;
    out_d    = out_q;
    wcnt_d   = wcnt_q;
    bc_d     = bc_q;
    rx_deq_o = 1'b0;
    tx_enq_o = 1'b0;
    case (state_q)
      IDLE: if (key_ready_i && !rx_empty_i) begin
        state_d = LOAD;
        mode_d  = is_encrypt_i;
        cnt_d   = '0;
      end
      LOAD: begin
        rx_deq_o = !rx_empty_i;
        if (!rx_empty_i) begin
          blk_d = {blk_q[W-9:0], rx_data_i};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = ISSUE;
        end
      end
      ISSUE: begin
        wcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wcnt_d = wcnt_q + 16'd1;
        // a result arriving on the final allowed cycle still counts
        if (core_done_i) begin
          out_d   = core_block_out_i;
          cnt_d   = '0;
          state_d = UNLOAD;
        end else if (wcnt_d == 16'(CORE_TIMEOUT)) begin
          err_d   = 1'b1;
          blk_d   = '0;
          state_d = IDLE;
        end
      end
      UNLOAD: begin
        tx_enq_o = !tx_full_i;
        if (!tx_full_i) begin
          out_d = {out_q[W-9:0], 8'h00};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            bc_d    = bc_q + 16'd1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign core_start_o    = state_q == ISSUE;
  assign core_mode_o     = mode_q;
  assign core_block_in_o = blk_q;
  assign tx_data_o       = out_q[W-1:W-8];
  assign busy_o          = state_q != IDLE;
  assign timeout_err_o   = err_q;
  assign block_count_o   = bc_q;
endmodule

// File: tb/tb_cipher_block_sequencer.sv
// tb_cipher_block_sequencer: scoreboard bench with Rx FIFO and echo-inverting cipher core models
module tb_cipher_block_sequencer;
  localparam int W = 64;
  logic clk = 1'b0, n_reset = 1'b0;
  logic key_ready = 1'b0, is_encrypt = 1'b0, rx_empty = 1'b1, core_done = 1'b0, tx_full = 1'b0, err_clr = 1'b0;
  logic [7:0] rx_data = '0;
  logic [W-1:0] core_block_out = '0;
  logic rx_deq, core_start, core_mode, tx_enq, busy, timeout_err;
  logic [W-1:0] core_block_in;
  logic [7:0] tx_data;
  logic [15:0] block_count;
  always #5 clk = ~clk;
  cipher_block_sequencer dut (
    .clk(clk), .n_reset(n_reset), .key_ready_i(key_ready), .is_encrypt_i(is_encrypt),
    .rx_empty_i(rx_empty), .rx_data_i(rx_data), .rx_deq_o(rx_deq), .core_start_o(core_start),
    .core_mode_o(core_mode), .core_block_in_o(core_block_in), .core_done_i(core_done),
    .core_block_out_i(core_block_out), .tx_full_i(tx_full), .tx_data_o(tx_data), .tx_enq_o(tx_enq),
    .err_clr_i(err_clr), .busy_o(busy), .timeout_err_o(timeout_err), .block_count_o(block_count)
  );
  int checks = 0, failures = 0;
  logic [7:0] rxq[$];
  logic [7:0] exp_tx[$];
  logic [W:0] exp_blk[$];
  int cyc = 0, last_deq = 0, done_cyc = 0, deq_cnt = 0, start_cnt = 0, wait_cyc = 0;
  int core_cnt = 0, core_lat = 10;
  bit core_en = 1'b1, lat_chk = 1'b1, first_enq = 1'b0, counting = 1'b0;
  logic [W-1:0] core_latch = '0;
  logic m_deq, m_enq, m_start, m_busy, m_err, m_done;
  logic [7:0] m_tx;
  task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // one clock: refresh Rx view, sample at negedge, apply FIFO pop and core response after the edge
  task automatic tick();
    rx_empty = rxq.size() == 0;
    rx_data  = rx_empty ? 8'h00 : rxq[0];
    @(negedge clk);
    cyc++;
    m_deq = rx_deq; m_enq = tx_enq; m_start = core_start; m_busy = busy;
    m_err = timeout_err; m_done = core_done; m_tx = tx_data;
    if (m_deq && m_enq) check("deq_enq_excl", 1, 0);
    if (m_deq) begin last_deq = cyc; deq_cnt++; end
    if (m_start) begin
      start_cnt++;
      check("start_lat", cyc - last_deq, 1);
      if (exp_blk.size() == 0) check("blk_unexpected", 1, 0);
      else check("block_in", {core_mode, core_block_in}, exp_blk.pop_front());
      if (core_en) core_cnt = core_lat;
      core_latch = core_block_in;
      wait_cyc = 0;
      counting = 1'b1;
    end else if (counting) begin
      if (m_busy) wait_cyc++;
      else counting = 1'b0;
    end
    if (m_done) begin done_cyc = cyc; first_enq = 1'b1; end
    if (m_enq) begin
      if (first_enq && lat_chk) check("enq_lat", cyc - done_cyc, 1);
      first_enq = 1'b0;
      if (exp_tx.size() == 0) check("tx_unexpected", 1, 0);
      else check("tx_data", m_tx, exp_tx.pop_front());
    end
    @(posedge clk);
    #1;
    if (m_deq) void'(rxq.pop_front());
    core_done = 1'b0;
    if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0) begin
        core_done = 1'b1;
        core_block_out = ~core_latch;
      end
    end
  endtask
  task automatic push_rx(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) rxq.push_back(first + 8'(i));
  endtask
  task automatic expect_blk(input logic [7:0] first, input logic mode, input bit out);
    logic [W-1:0] b = '0;
    for (int i = 0; i < 8; i++) begin
      b = {b[W-9:0], first + 8'(i)};
      if (out) exp_tx.push_back(~(first + 8'(i)));
    end
    exp_blk.push_back({mode, b});
  endtask
  task automatic run_idle(input string tag);
    bit seen = 1'b0;
    int n = 0;
    do begin
      tick();
      n++;
      if (m_busy) seen = 1'b1;
    end while ((!seen || m_busy) && n < 2000);
    check({tag, "_idle"}, {seen, m_busy}, 2'b10);
  endtask
  initial begin
    int n, d0, s0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_strobes", {rx_deq, core_start, tx_enq}, 0);
    check("rst_err_mode", {timeout_err, core_mode}, 0);
    check("rst_count", block_count, 0);
    check("rst_block", core_block_in, 0);
    check("rst_txdata", tx_data, 0);
    n_reset = 1'b1;
    key_ready = 1'b1; is_encrypt = 1'b1;
    push_rx(8'h00, 8); expect_blk(8'h00, 1'b1, 1'b1);
    run_idle("t1");
    check("t1_count", block_count, 1);
    check("t1_tx_all", exp_tx.size(), 0);
    key_ready = 1'b0; is_encrypt = 1'b0;
    push_rx(8'h10, 8); expect_blk(8'h10, 1'b0, 1'b1);
    d0 = deq_cnt;
    repeat (6) tick();
    check("t2_no_deq", deq_cnt - d0, 0);
    check("t2_idle", m_busy, 0);
    key_ready = 1'b1;
    tick(); tick();
    check("t2_load", {m_busy, m_deq}, 2'b11);
    key_ready = 1'b0; is_encrypt = 1'b1;
    run_idle("t2");
    check("t2_count", block_count, 2);
    key_ready = 1'b1;
    push_rx(8'h20, 3); expect_blk(8'h20, 1'b1, 1'b1);
    d0 = deq_cnt;
    repeat (6) tick();
    s0 = start_cnt;
    repeat (20) tick();
    check("t3_stall_busy", m_busy, 1);
    check("t3_no_start", start_cnt - s0, 0);
    check("t3_deq3", deq_cnt - d0, 3);
    push_rx(8'h23, 5);
    run_idle("t3");
    check("t3_count", block_count, 3);
    tx_full = 1'b1; lat_chk = 1'b0;
    push_rx(8'h30, 8); expect_blk(8'h30, 1'b1, 1'b1);
    n = 0;
    do begin tick(); n++; end while (!m_done && n < 200);
    check("t4_done_seen", m_done, 1);
    repeat (5) begin
      tick();
      check("t4_hold_enq", m_enq, 0);
      check("t4_hold_data", m_tx, exp_tx.size() > 0 ? exp_tx[0] : 8'h00);
    end
    tx_full = 1'b0;
    run_idle("t4");
    lat_chk = 1'b1;
    check("t4_count", block_count, 4);
    check("t4_tx_all", exp_tx.size(), 0);
    core_en = 1'b0;
    push_rx(8'h40, 8); expect_blk(8'h40, 1'b1, 1'b0);
    run_idle("t5");
    check("t5_err", m_err, 1);
    check("t5_wait_cycles", wait_cyc, 255);
    check("t5_count", block_count, 4);
    err_clr = 1'b1;
    tick();
    check("t5_clr", timeout_err, 0);
    err_clr = 1'b0;
    core_en = 1'b1; core_lat = 255; is_encrypt = 1'b0;
    push_rx(8'h50, 8); expect_blk(8'h50, 1'b0, 1'b1);
    run_idle("t6");
    check("t6_no_err", m_err, 0);
    check("t6_count", block_count, 5);
    core_lat = 10;
    err_clr = 1'b1; core_en = 1'b0;
    push_rx(8'h58, 8); expect_blk(8'h58, 1'b0, 1'b0);
    run_idle("t7");
    check("t7_set_wins", m_err, 1);
    tick();
    check("t7_clr", m_err, 0);
    err_clr = 1'b0; core_en = 1'b1;
    force dut.bc_q = 16'hFFFF;
    #1;
    release dut.bc_q;
    push_rx(8'h60, 8); expect_blk(8'h60, 1'b0, 1'b1);
    run_idle("t8");
    check("t8_wrap", block_count, 0);
    core_lat = 50;
    push_rx(8'h70, 8); expect_blk(8'h70, 1'b0, 1'b0);
    s0 = start_cnt; n = 0;
    do begin tick(); n++; end while (start_cnt == s0 && n < 200);
    repeat (5) tick();
    check("t9_in_wait", m_busy, 1);
    #2 n_reset = 1'b0;
    #1;
    check("t9_busy", busy, 0);
    check("t9_strobes", {rx_deq, core_start, tx_enq, core_mode, timeout_err}, 0);
    check("t9_count", block_count, 0);
    check("t9_block", core_block_in, 0);
    check("t9_txdata", tx_data, 0);
    core_cnt = 0; core_done = 1'b0;
    tick(); tick();
    n_reset = 1'b1;
    repeat (3) tick();
    check("t9_idle_after", m_busy, 0);
    check("sb_empty", {exp_blk.size() == 0, exp_tx.size() == 0, rxq.size() == 0}, 3'b111);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end
endmodule
